genie_mem_bridge: RTL and testbench

Downstream memory stage of the Genie accelerator top: converts Genie's single-outstanding data-bus handshake into accesses to a synchronous single-port SRAM with fixed read latency. All layer traffic passes through this block: input/weight/bias loads and output stores from the FC and CV data loaders. It serialises reads and writes, enforces write-before-read ordering, flags out-of-range addresses, and keeps access counters for bring-up.

---
 rtl/genie_mem_pkg.sv | 33 +++
 rtl/genie_mem_bridge_if.sv | 19 +
 rtl/genie_rd_lat_cnt.sv | 27 ++
 rtl/genie_mem_bridge.sv | 119 +++++++++++
 tb/tb_genie_mem_bridge.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genie_mem_pkg.sv
// genie_mem_pkg: shared types and helpers for the Genie memory bridge.
//   GENIE_ADDR_W / GENIE_DATA_W : Genie data-bus address / data widths
//   state_e                     : bridge FSM states
//   req_t                       : request captured on leaving IDLE
//   addr_oor()                  : true when an address does not fit in the SRAM
package genie_mem_pkg;

  localparam int GENIE_ADDR_W = 26;
  localparam int GENIE_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_e;

  typedef struct packed {
    logic [GENIE_ADDR_W-1:0] addr;
    logic [GENIE_DATA_W-1:0] data;
  } req_t;

  // Any set bit at or above position aw makes the address unreachable.
  function automatic logic addr_oor(input logic [GENIE_ADDR_W-1:0] addr,
                                    input int unsigned aw);
    logic [GENIE_ADDR_W-1:0] hi_mask;
    hi_mask = '1;
    hi_mask = hi_mask << aw;
    return |(addr & hi_mask);
  endfunction

endpackage

// File: rtl/genie_mem_bridge_if.sv
// genie_mem_bridge_if: Genie single-outstanding data bus.
//   write channel : wvalid/waddr/wdata (master) -> wready pulse (slave)
//   read channel  : rvalid/raddr (master) -> rready pulse + rdata (slave)
// Requests are held by the master until the matching ready pulse.
interface genie_mem_bridge_if;
  logic                                   wvalid;
  logic                                   wready;
  logic [genie_mem_pkg::GENIE_ADDR_W-1:0] waddr;
  logic [genie_mem_pkg::GENIE_DATA_W-1:0] wdata;
  logic                                   rvalid;
  logic                                   rready;
  logic [genie_mem_pkg::GENIE_ADDR_W-1:0] raddr;
  logic [genie_mem_pkg::GENIE_DATA_W-1:0] rdata;

  modport master (output wvalid, waddr, wdata, rvalid, raddr,
                  input  wready, rready, rdata);
  modport slave  (input  wvalid, waddr, wdata, rvalid, raddr,
                  output wready, rready, rdata);
endinterface

// File: rtl/genie_rd_lat_cnt.sv
// genie_rd_lat_cnt: SRAM read-latency down-counter.
//   load : preload RD_LAT-1 (issued in the SRAM access cycle)
//   en   : count down while waiting, stops at zero
//   done : counter is zero, read data is on mem_rdata this cycle
module genie_rd_lat_cnt #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = 2;  // covers RD_LAT-1 up to 3

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (load)                cnt_q <= CW'(RD_LAT - 1);
    else if (en && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/genie_mem_bridge.sv
// genie_mem_bridge: Genie data bus -> synchronous single-port SRAM.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : Genie write/read request channels
//   mem_en/mem_we     : SRAM strobe / write enable
//   mem_addr/wdata    : SRAM address / write data
//   mem_rdata         : SRAM read data, RD_LAT cycles after mem_en
//   err_clr/err       : sticky out-of-range flag and its clear
//   rd_cnt/wr_cnt     : completed read / write counters (mod 2^32)
// One request at a time; writes win over a simultaneous read so a read of
// the same address always observes the write.
module genie_mem_bridge
  import genie_mem_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  genie_mem_bridge_if.slave       bus,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [GENIE_DATA_W-1:0] mem_wdata,
  input  logic [GENIE_DATA_W-1:0] mem_rdata,
  input  logic                    err_clr,
  output logic                    err,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt
);

  state_e                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [GENIE_DATA_W-1:0] rdata_q;
  logic                    err_q;
  logic [31:0]             rd_cnt_q, wr_cnt_q;

  logic cnt_load, cnt_en, cnt_done, rd_capture;
  logic req_oor;

  assign req_oor = addr_oor(req_q.addr, MEM_AW);

  genie_rd_lat_cnt #(.RD_LAT(RD_LAT)) u_lat (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .en   (cnt_en),
    .done (cnt_done)
  );

  // RD_WAIT always lasts at least one cycle: it is the cycle in which
  // mem_rdata for the access issued in RD_ISSUE is valid and sampled.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    rd_capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.wvalid) begin
          state_d = ST_WR;
          req_d   = '{addr: bus.waddr, data: bus.wdata};
        end else if (bus.rvalid) begin
          state_d = ST_RD_ISSUE;
          req_d   = '{addr: bus.raddr, data: '0};
        end
      end
      ST_WR:       state_d = ST_IDLE;
      ST_RD_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          rd_capture = 1'b1;
          state_d    = ST_RD_RESP;
        end
      end
      ST_RD_RESP:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      // An unreachable address never touched the SRAM, so return zero.
      if (rd_capture) rdata_q <= req_oor ? '0 : mem_rdata;
      // Setting wins over a same-cycle clear.
      if ((state_q == ST_WR || state_q == ST_RD_RESP) && req_oor) err_q <= 1'b1;
      else if (err_clr)                                            err_q <= 1'b0;
      if (state_q == ST_WR)      wr_cnt_q <= wr_cnt_q + 32'd1;
      if (state_q == ST_RD_RESP) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  // All outputs decode registered state only; no input reaches an output
  // combinationally.
  assign mem_en     = (state_q == ST_WR || state_q == ST_RD_ISSUE) && !req_oor;
  assign mem_we     = (state_q == ST_WR) && !req_oor;
  assign mem_addr   = req_q.addr[MEM_AW-1:0];
  assign mem_wdata  = req_q.data;
  assign bus.wready = (state_q == ST_WR);
  assign bus.rready = (state_q == ST_RD_RESP);
  assign bus.rdata  = (state_q == ST_RD_RESP) ? rdata_q : '0;
  assign err        = err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_genie_mem_bridge.sv
// tb_genie_mem_bridge: directed bench. Lane 0 (RD_LAT=2) carries the
// functional scenarios; lanes 1..4 (RD_LAT=1..4) carry the latency sweep.
// Each lane has its own SRAM model preloaded with 0xC0DE_0000 | index.
module tb_genie_mem_bridge;
  import genie_mem_pkg::*;

  localparam int NI = 5;
  localparam int L0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]        wvalid_a = '0, rvalid_a = '0, err_clr_a = '0;
  logic [NI-1:0][25:0]  waddr_a = '0, raddr_a = '0;
  logic [NI-1:0][31:0]  wdata_a = '0;
  logic [NI-1:0]        wready_a, rready_a, mem_en_a, err_a;
  logic [NI-1:0][31:0]  rdata_a, rd_cnt_a, wr_cnt_a, en_cnt_a;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? L0 : g;
    genie_mem_bridge_if bus ();
    logic        men, mwe;
    logic [15:0] maddr;
    logic [31:0] mwdata, mrdata;
    logic [31:0] ram  [0:1023];
    logic [31:0] pipe [0:3];
    int          en_cnt = 0;

    assign bus.wvalid  = wvalid_a[g];
    assign bus.waddr   = waddr_a[g];
    assign bus.wdata   = wdata_a[g];
    assign bus.rvalid  = rvalid_a[g];
    assign bus.raddr   = raddr_a[g];
    assign wready_a[g] = bus.wready;
    assign rready_a[g] = bus.rready;
    assign rdata_a[g]  = bus.rdata;
    assign mem_en_a[g] = men;
    assign en_cnt_a[g] = en_cnt;

    genie_mem_bridge #(.MEM_AW(16), .RD_LAT(L)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .mem_en   (men),
      .mem_we   (mwe),
      .mem_addr (maddr),
      .mem_wdata(mwdata),
      .mem_rdata(mrdata),
      .err_clr  (err_clr_a[g]),
      .err      (err_a[g]),
      .rd_cnt   (rd_cnt_a[g]),
      .wr_cnt   (wr_cnt_a[g])
    );

    initial for (int i = 0; i < 1024; i++) ram[i] = 32'hC0DE_0000 | i;

    // Junk word when no read was issued, so a mistimed capture is visible.
    always @(posedge clk) begin
      if (men && mwe) ram[maddr[9:0]] <= mwdata;
      pipe[0] <= (men && !mwe) ? ram[maddr[9:0]] : 32'hBAD0_BAD0;
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      if (men) en_cnt <= en_cnt + 1;
    end
    assign mrdata = pipe[L-1];
  end

  // ---------------- lane-0 drivers (no checking inside) ----------------
  task automatic do_write(input logic [25:0] a, input logic [31:0] d, output int lat);
    int unsigned t0;
    @(negedge clk);
    wvalid_a[0] = 1'b1; waddr_a[0] = a; wdata_a[0] = d;
    t0 = cyc; lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wready_a[0]) begin lat = int'(cyc - t0); break; end
    end
    wvalid_a[0] = 1'b0;
  endtask

  task automatic do_read(input logic [25:0] a, output int lat, output logic [31:0] d);
    int unsigned t0;
    @(negedge clk);
    rvalid_a[0] = 1'b1; raddr_a[0] = a;
    t0 = cyc; lat = -1; d = 'x;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rready_a[0]) begin lat = int'(cyc - t0); d = rdata_a[0]; break; end
    end
    rvalid_a[0] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({wready_a[0], rready_a[0], mem_en_a[0], err_a[0]} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {wready_a[0], rready_a[0], mem_en_a[0], err_a[0]});
    end
    checks++;
    if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata_a[0]); end
    checks++;
    if (rd_cnt_a[0] !== 32'h0 || wr_cnt_a[0] !== 32'h0) begin
      errors++; $display("FAIL reset_cnt rd=%h wr=%h want=0", rd_cnt_a[0], wr_cnt_a[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({wready_a[0], rready_a[0], mem_en_a[0]} !== 3'b0) begin
      errors++; $display("FAIL idle_ctrl got=%b want=000", {wready_a[0], rready_a[0], mem_en_a[0]});
    end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] d; logic [31:0] e0;
    e0 = en_cnt_a[0];
    do_write(26'h10, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL wr_latency got=%0d want=1", lat); end
    do_read(26'h10, lat, d);
    checks++;
    if (lat !== L0 + 2) begin errors++; $display("FAIL rd_latency got=%0d want=%0d", lat, L0 + 2); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h want=deadbeef", d); end
    @(negedge clk);
    checks++;
    if (wr_cnt_a[0] !== 32'd1 || rd_cnt_a[0] !== 32'd1) begin
      errors++; $display("FAIL wr_rd_cnt wr=%0d rd=%0d want=1/1", wr_cnt_a[0], rd_cnt_a[0]);
    end
    checks++;
    if (en_cnt_a[0] - e0 !== 32'd2) begin errors++; $display("FAIL mem_en_count got=%0d want=2", en_cnt_a[0] - e0); end
  endtask

  task automatic test_priority;
    int unsigned t0; int lat; logic [31:0] d;
    @(negedge clk);
    wvalid_a[0] = 1'b1; waddr_a[0] = 26'h20; wdata_a[0] = 32'h1234_5678;
    rvalid_a[0] = 1'b1; raddr_a[0] = 26'h20;
    t0 = cyc;
    @(negedge clk);
    checks++;
    if ({wready_a[0], rready_a[0]} !== 2'b10) begin
      errors++; $display("FAIL prio_first got wready,rready=%b want=10", {wready_a[0], rready_a[0]});
    end
    wvalid_a[0] = 1'b0;
    lat = -1; d = 'x;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rready_a[0]) begin lat = int'(cyc - t0); d = rdata_a[0]; break; end
    end
    rvalid_a[0] = 1'b0;
    checks++;
    if (lat !== L0 + 4) begin errors++; $display("FAIL prio_rd_latency got=%0d want=%0d", lat, L0 + 4); end
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL prio_rd_data got=%h want=12345678", d); end
    @(negedge clk);
    checks++;
    if (wr_cnt_a[0] !== 32'd2 || rd_cnt_a[0] !== 32'd2) begin
      errors++; $display("FAIL prio_cnt wr=%0d rd=%0d want=2/2", wr_cnt_a[0], rd_cnt_a[0]);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] d; logic [31:0] e0;
    // Clear held across the bad read: the set must still win.
    err_clr_a[0] = 1'b1;
    e0 = en_cnt_a[0];
    do_read(26'h100_0000, lat, d);
    checks++;
    if (lat !== L0 + 2 || d !== 32'h0) begin
      errors++; $display("FAIL oor_rd got lat=%0d data=%h want lat=%0d data=0", lat, d, L0 + 2);
    end
    err_clr_a[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (err_a[0] !== 1'b1) begin errors++; $display("FAIL oor_err_set got=%b want=1", err_a[0]); end
    checks++;
    if (en_cnt_a[0] !== e0) begin errors++; $display("FAIL oor_rd_no_mem_en got=%0d want=0", en_cnt_a[0] - e0); end
    // Bad write aliases to 0x10 in the low bits; it must not land.
    do_write(26'h200_0010, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL oor_wr_ack got=%0d want=1", lat); end
    checks++;
    if (en_cnt_a[0] !== e0) begin errors++; $display("FAIL oor_wr_no_mem_en got=%0d want=0", en_cnt_a[0] - e0); end
    do_read(26'h10, lat, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_wr_dropped got=%h want=deadbeef", d); end
    @(negedge clk);
    checks++;
    if (err_a[0] !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err_a[0]); end
    err_clr_a[0] = 1'b1;
    @(negedge clk);
    err_clr_a[0] = 1'b0;
    checks++;
    if (err_a[0] !== 1'b0) begin errors++; $display("FAIL err_clr got=%b want=0", err_a[0]); end
    checks++;
    if (wr_cnt_a[0] !== 32'd3 || rd_cnt_a[0] !== 32'd4) begin
      errors++; $display("FAIL oor_cnt wr=%0d rd=%0d want=3/4", wr_cnt_a[0], rd_cnt_a[0]);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic seen;
    @(negedge clk);
    rvalid_a[0] = 1'b1; raddr_a[0] = 26'h10;
    @(negedge clk);                 // RD_ISSUE
    @(negedge clk);                 // RD_WAIT
    rst_n = 1'b0; rvalid_a[0] = 1'b0;
    #1;
    checks++;
    if ({wready_a[0], rready_a[0], mem_en_a[0]} !== 3'b0 || rdata_a[0] !== 32'h0 || rd_cnt_a[0] !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs ctrl=%b rdata=%h rd_cnt=%h want=0", {wready_a[0], rready_a[0], mem_en_a[0]}, rdata_a[0], rd_cnt_a[0]);
    end
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (rready_a[0] || wready_a[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ready got=1 want=0"); end
    do_read(26'h10, lat, d);
    checks++;
    if (lat !== L0 + 2 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rst_mid_next_rd lat=%0d data=%h want lat=%0d data=deadbeef", lat, d, L0 + 2);
    end
    @(negedge clk);
    checks++;
    if (rd_cnt_a[0] !== 32'd1) begin errors++; $display("FAIL rst_mid_cnt got=%0d want=1", rd_cnt_a[0]); end
  endtask

  task automatic sweep_lane(input int l);
    int unsigned t0, prev;
    logic seen;
    @(negedge clk);
    rvalid_a[l] = 1'b1; raddr_a[l] = 26'd0;
    t0 = cyc; prev = cyc;
    for (int i = 0; i < 64; i++) begin
      seen = 1'b0;
      for (int n = 0; n < 16 && !seen; n++) begin
        @(negedge clk);
        if (rready_a[l]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL sweep_timeout lat=%0d read=%0d", l, i); break; end
      checks++;
      if (i == 0 && cyc - t0 !== l + 2) begin
        errors++; $display("FAIL sweep_first lat=%0d got=%0d want=%0d", l, cyc - t0, l + 2);
      end else if (i != 0 && cyc - prev !== l + 3) begin
        errors++; $display("FAIL sweep_spacing lat=%0d read=%0d got=%0d want=%0d", l, i, cyc - prev, l + 3);
      end
      checks++;
      if (rdata_a[l] !== (32'hC0DE_0000 | i)) begin
        errors++; $display("FAIL sweep_data lat=%0d read=%0d got=%h want=%h", l, i, rdata_a[l], 32'hC0DE_0000 | i);
      end
      prev = cyc;
      raddr_a[l] = 26'(i + 1);
    end
    rvalid_a[l] = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_cnt_a[l] !== 32'd64) begin errors++; $display("FAIL sweep_cnt lat=%0d got=%0d want=64", l, rd_cnt_a[l]); end
  endtask

  task automatic test_back_to_back;
    fork
      sweep_lane(1);
      sweep_lane(2);
      sweep_lane(3);
      sweep_lane(4);
    join
  endtask

  task automatic test_cnt_wrap;
    int lat; logic [31:0] d;
    @(negedge clk);
    force g_dut[0].dut.rd_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release g_dut[0].dut.rd_cnt_q;
    @(negedge clk);
    checks++;
    if (rd_cnt_a[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffffffff", rd_cnt_a[0]); end
    do_read(26'h20, lat, d);
    @(negedge clk);
    checks++;
    if (rd_cnt_a[0] !== 32'h0) begin errors++; $display("FAIL wrap_rd_cnt got=%h want=0", rd_cnt_a[0]); end
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL wrap_rd_data got=%h want=12345678", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_cnt_wrap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
